// File: rtl/sampstream_pkg.sv
// Shared constants for the sample-stream framer: FSM state codes, default
// sync byte, header length and a byte-lane helper.
package sampstream_pkg;

  // FSM state codes (plain constants so older tools and dumps read them as numbers)
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_SYNC = 4'd1;
  localparam logic [3:0] ST_SEQ  = 4'd2;
  localparam logic [3:0] ST_CNT  = 4'd3;
  localparam logic [3:0] ST_LOAD = 4'd4;
  localparam logic [3:0] ST_B0   = 4'd5;
  localparam logic [3:0] ST_B1   = 4'd6;
  localparam logic [3:0] ST_B2   = 4'd7;
  localparam logic [3:0] ST_B3   = 4'd8;
  localparam logic [3:0] ST_CSUM = 4'd9;

  // First byte of every packet; the host resynchronises on it
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Sync, sequence and count bytes precede the sample bytes
  localparam int HDR_LEN = 3;

  // Little-endian byte lane idx of a 32-bit sample
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    return w[8*idx +: 8];
  endfunction

endpackage

// File: rtl/sampstream_framer_byte_out.sv
// Registered byte output stage. Holds out_data/out_valid steady until the
// framer either loads the next byte or clears the stage after acceptance.
module byte_out_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] load_data,
  output logic [7:0] out_data,
  output logic       out_valid
);

  logic [7:0] data_reg;
  logic       valid_reg;

  // Capture a new byte on load, drop valid on clear, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg  <= 8'h00;
      valid_reg <= 1'b0;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/sampstream_framer.sv
// Pulls 32-bit samples from the sample queue stream port and frames them as
// byte packets: sync, seq, count, little-endian sample bytes, XOR checksum.
module sampstream_framer
  import sampstream_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] samp_stream_data,
  input  logic [7:0]  samp_stream_count,
  input  logic        samp_stream_avail,
  output logic        samp_stream_pull,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  seq,
  output logic        busy
);

  localparam int              SW         = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]   SETTLE_MAX = SW'(SETTLE_CYCLES);

  logic [3:0]    state_reg, state_next;
  logic [SW-1:0] settle_cnt_reg;
  logic [7:0]    remain_reg, remain_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [31:0]   shift_reg, shift_next;
  logic [7:0]    csum_reg, csum_next;
  logic [7:0]    seq_reg, seq_next;

  logic       settled;
  logic       accept;
  logic       pull;
  logic       byte_load;
  logic       byte_clear;
  logic [7:0] byte_data;

  // Queue outputs are registered and head data comes from a RAM read, so
  // they are only trusted once the settle counter has saturated.
  assign settled = (settle_cnt_reg == SETTLE_MAX);
  assign accept  = out_valid && out_ready;
  assign pull    = (state_reg == ST_LOAD) && settled && samp_stream_avail;

  assign samp_stream_pull = pull;
  assign seq              = seq_reg;
  assign busy             = (state_reg != ST_IDLE);

  // Settle counter: restart on every pull, saturate once the stream is stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt_reg <= SETTLE_MAX;
    end else if (pull) begin
      settle_cnt_reg <= '0;
    end else if (!settled) begin
      settle_cnt_reg <= settle_cnt_reg + 1'b1;
    end
  end

  // Packet FSM: picks the next byte for the output stage and tracks checksum
  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    csum_next   = csum_reg;
    seq_next    = seq_reg;
    byte_load   = 1'b0;
    byte_clear  = 1'b0;
    byte_data   = 8'h00;

    case (state_reg)
      ST_IDLE: begin
        if (enable && samp_stream_avail && settled && (samp_stream_count != 8'd0)) begin
          cnt_next    = samp_stream_count;
          remain_next = samp_stream_count;
          csum_next   = 8'h00;
          byte_load   = 1'b1;
          byte_data   = SYNC_BYTE;
          state_next  = ST_SYNC;
        end
      end
      ST_SYNC: begin
        // Sync byte is not covered by the checksum
        if (accept) begin
          byte_load  = 1'b1;
          byte_data  = seq_reg;
          state_next = ST_SEQ;
        end
      end
      ST_SEQ: begin
        if (accept) begin
          csum_next  = csum_reg ^ out_data;
          byte_load  = 1'b1;
          byte_data  = cnt_reg;
          state_next = ST_CNT;
        end
      end
      ST_CNT: begin
        if (accept) begin
          csum_next  = csum_reg ^ out_data;
          byte_clear = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Pull and capture happen in the same cycle; the head word is valid now
        if (pull) begin
          shift_next  = samp_stream_data;
          remain_next = remain_reg - 8'd1;
          byte_load   = 1'b1;
          byte_data   = samp_stream_data[7:0];
          state_next  = ST_B0;
        end
      end
      ST_B0, ST_B1, ST_B2: begin
        if (accept) begin
          csum_next  = csum_reg ^ out_data;
          byte_load  = 1'b1;
          byte_data  = word_byte(shift_reg, 2'(state_reg - ST_B0 + 4'd1));
          state_next = state_reg + 4'd1;
        end
      end
      ST_B3: begin
        if (accept) begin
          csum_next = csum_reg ^ out_data;
          if (remain_reg != 8'd0) begin
            byte_clear = 1'b1;
            state_next = ST_LOAD;
          end else begin
            byte_load  = 1'b1;
            byte_data  = csum_reg ^ out_data;
            state_next = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          seq_next   = seq_reg + 8'd1;
          byte_clear = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        byte_clear = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; a reset abandons any partial packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      remain_reg <= 8'h00;
      cnt_reg    <= 8'h00;
      shift_reg  <= 32'h0;
      csum_reg   <= 8'h00;
      seq_reg    <= 8'h00;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      csum_reg   <= csum_next;
      seq_reg    <= seq_next;
    end
  end

  byte_out_reg u_byte_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (byte_load),
    .clear     (byte_clear),
    .load_data (byte_data),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_sampstream_framer.sv
// Bench for sampstream_framer: a registered sample-queue model feeds the DUT,
// a monitor collects accepted bytes and pull events, and each scenario task
// compares against packets built directly from the framing rules.
module tb_sampstream_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] samp_stream_data  = 32'h0;
  logic [7:0]  samp_stream_count = 8'h0;
  logic        samp_stream_avail = 1'b0;
  logic        samp_stream_pull;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  seq;
  logic        busy;

  always #5 clk = ~clk;

  sampstream_framer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .enable            (enable),
    .samp_stream_data  (samp_stream_data),
    .samp_stream_count (samp_stream_count),
    .samp_stream_avail (samp_stream_avail),
    .samp_stream_pull  (samp_stream_pull),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .seq               (seq),
    .busy              (busy)
  );

  // ---------------- upstream sample queue model ----------------
  logic [31:0] mem [0:255];
  logic [15:0] wr_ptr = 16'd0;
  logic [15:0] rd_ptr = 16'd0;
  logic [15:0] cap    = 16'd255;

  // Pointer moves on pull; count/avail/head word are registered views of it
  always @(posedge clk) begin
    if (samp_stream_pull) rd_ptr <= rd_ptr + 16'd1;
    samp_stream_data  <= mem[rd_ptr[7:0]];
    samp_stream_avail <= (wr_ptr != rd_ptr);
    samp_stream_count <= 8'(((wr_ptr - rd_ptr) > cap) ? cap : (wr_ptr - rd_ptr));
  end

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [7:0]  got[$];
  int          pull_cnt  = 0;
  int          gap_err   = 0;
  int          avail_err = 0;
  int          stab_err  = 0;
  int          last_pull = -100;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_hold && (out_valid !== 1'b1 || out_data !== prev_data)) stab_err <= stab_err + 1;
    prev_hold <= out_valid && !out_ready;
    prev_data <= out_data;
    if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
    if (samp_stream_pull === 1'b1) begin
      pull_cnt <= pull_cnt + 1;
      if (cyc - last_pull < 3) gap_err <= gap_err + 1;
      if (samp_stream_avail !== 1'b1) avail_err <= avail_err + 1;
      last_pull <= cyc;
    end
  end

  // ---------------- reference model ----------------
  int          checks = 0;
  int          errors = 0;
  int          exp_seq = 0;
  logic [31:0] samples[$];
  logic [7:0]  exp_pk[$];

  // Packet = A5, seq, n, little-endian bytes of n samples, XOR of all but A5
  task automatic make_expected(input logic [7:0] s, input int n);
    logic [7:0] x;
    logic [7:0] b;
    exp_pk.delete();
    exp_pk.push_back(8'hA5);
    exp_pk.push_back(s);
    exp_pk.push_back(8'(n));
    x = s ^ 8'(n);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'(samples[i] >> (8 * k));
        exp_pk.push_back(b);
        x = x ^ b;
      end
    end
    exp_pk.push_back(x);
  endtask

  function automatic int first_diff();
    int n;
    n = (got.size() < exp_pk.size()) ? got.size() : exp_pk.size();
    for (int i = 0; i < n; i++) if (got[i] !== exp_pk[i]) return i;
    if (got.size() != exp_pk.size()) return n;
    return -1;
  endfunction

  function automatic logic [7:0] got_at(input int i);
    return (i >= 0 && i < got.size()) ? got[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int i);
    return (i >= 0 && i < exp_pk.size()) ? exp_pk[i] : 8'hxx;
  endfunction

  task automatic push(input logic [31:0] v);
    mem[wr_ptr[7:0]] = v;
    wr_ptr = wr_ptr + 16'd1;
    samples.push_back(v);
  endtask

  // Drive out_ready each cycle until nbytes have been accepted or budget runs out
  task automatic run_packet(input int nbytes, input bit rnd, input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (got.size() >= nbytes) begin
        to = 1'b0;
        break;
      end
    end
    out_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || samp_stream_pull !== 1'b0 || busy !== 1'b0 ||
        seq !== 8'h00 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: valid=%b pull=%b busy=%b seq=%02h data=%02h, required 0 0 0 00 00",
               out_valid, samp_stream_pull, busy, seq, out_data);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_single();
    bit to; int d; int p0;
    got.delete(); samples.delete();
    p0 = pull_cnt;
    enable = 1'b1;
    push(32'h11223344);
    make_expected(8'(exp_seq), 1);
    run_packet(8, 1'b0, 200, to);
    repeat (3) @(posedge clk); #1;
    d = first_diff();
    checks++;
    if (to || d >= 0) begin
      errors++;
      $display("FAIL single_pkt: timeout=%0d byte %0d got %02h required %02h (len %0d vs %0d)",
               to, d, got_at(d), exp_at(d), got.size(), exp_pk.size());
    end
    $display("single_pkt: %0d bytes, checksum %02h", got.size(), got_at(7));
    checks++;
    if (pull_cnt - p0 != 1) begin
      errors++;
      $display("FAIL single_pulls: got %0d required 1", pull_cnt - p0);
    end
    exp_seq++;
    checks++;
    if (seq !== 8'(exp_seq)) begin
      errors++;
      $display("FAIL single_seq: got %02h required %02h", seq, 8'(exp_seq));
    end
  endtask

  task automatic test_three();
    bit to; int d; int p0; int g0;
    got.delete(); samples.delete();
    p0 = pull_cnt; g0 = gap_err;
    push(32'd1); push(32'd2); push(32'd3);
    make_expected(8'(exp_seq), 3);
    run_packet(16, 1'b0, 300, to);
    repeat (3) @(posedge clk); #1;
    d = first_diff();
    checks++;
    if (to || d >= 0) begin
      errors++;
      $display("FAIL three_pkt: timeout=%0d byte %0d got %02h required %02h (len %0d vs %0d)",
               to, d, got_at(d), exp_at(d), got.size(), exp_pk.size());
    end
    $display("three_pkt: %0d bytes, %0d pulls", got.size(), pull_cnt - p0);
    checks++;
    if (pull_cnt - p0 != 3) begin
      errors++;
      $display("FAIL three_pulls: got %0d required 3", pull_cnt - p0);
    end
    checks++;
    if (gap_err != g0) begin
      errors++;
      $display("FAIL three_pull_spacing: %0d pulls closer than 3 cycles, required 0", gap_err - g0);
    end
    exp_seq++;
  endtask

  task automatic test_random_ready();
    bit to; int d; int s0;
    got.delete(); samples.delete();
    s0 = stab_err;
    for (int i = 0; i < 5; i++) push($urandom);
    make_expected(8'(exp_seq), 5);
    run_packet(24, 1'b1, 1000, to);
    repeat (3) @(posedge clk); #1;
    d = first_diff();
    checks++;
    if (to || d >= 0) begin
      errors++;
      $display("FAIL rand_ready_pkt: timeout=%0d byte %0d got %02h required %02h (len %0d vs %0d)",
               to, d, got_at(d), exp_at(d), got.size(), exp_pk.size());
    end
    $display("rand_ready_pkt: %0d bytes", got.size());
    checks++;
    if (stab_err != s0) begin
      errors++;
      $display("FAIL rand_ready_hold: %0d changes while stalled, required 0", stab_err - s0);
    end
    exp_seq++;
  endtask

  task automatic test_seq_wrap();
    bit to; int d;
    for (int p = 0; p < 256; p++) begin
      got.delete(); samples.delete();
      push($urandom);
      make_expected(8'(exp_seq), 1);
      run_packet(8, 1'b0, 200, to);
      d = first_diff();
      checks++;
      if (to || d >= 0) begin
        errors++;
        $display("FAIL wrap_pkt%0d: timeout=%0d byte %0d got %02h required %02h",
                 p, to, d, got_at(d), exp_at(d));
        break;
      end
      exp_seq++;
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (seq !== 8'(exp_seq)) begin
      errors++;
      $display("FAIL wrap_seq: got %02h required %02h", seq, 8'(exp_seq));
    end
    $display("seq_wrap: final seq %02h", seq);
  endtask

  task automatic test_enable_drop();
    bit to; int d; int p0; logic [31:0] left;
    got.delete(); samples.delete();
    p0 = pull_cnt;
    cap = 16'd2;
    push($urandom); push($urandom); push($urandom);
    make_expected(8'(exp_seq), 2);
    to = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (enable && got.size() >= 4) enable = 1'b0;
      if (got.size() >= 12) begin
        to = 1'b0;
        break;
      end
    end
    repeat (20) @(posedge clk); #1;
    d = first_diff();
    checks++;
    if (to || d >= 0) begin
      errors++;
      $display("FAIL en_drop_pkt: timeout=%0d byte %0d got %02h required %02h (len %0d vs %0d)",
               to, d, got_at(d), exp_at(d), got.size(), exp_pk.size());
    end
    checks++;
    if (busy !== 1'b0 || samp_stream_avail !== 1'b1 || pull_cnt - p0 != 2) begin
      errors++;
      $display("FAIL en_drop_idle: busy=%b avail=%b pulls=%0d, required 0 1 2",
               busy, samp_stream_avail, pull_cnt - p0);
    end
    $display("enable_drop: %0d bytes, %0d pulls", got.size(), pull_cnt - p0);
    exp_seq++;
    cap = 16'd255;
    left = samples[2];
    samples.delete();
    samples.push_back(left);
  endtask

  task automatic test_reset_mid_packet();
    bit to; int d; int p0;
    got.delete();
    enable = 1'b1;
    to = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (got.size() >= 1) begin
        to = 1'b0;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (to || out_valid !== 1'b0 || samp_stream_pull !== 1'b0 || seq !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: timeout=%0d valid=%b pull=%b seq=%02h busy=%b, required 0 0 00 0",
               to, out_valid, samp_stream_pull, seq, busy);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    got.delete();
    p0 = pull_cnt;
    exp_seq = 0;
    make_expected(8'h00, 1);
    run_packet(8, 1'b0, 200, to);
    d = first_diff();
    checks++;
    if (to || d >= 0) begin
      errors++;
      $display("FAIL post_reset_pkt: timeout=%0d byte %0d got %02h required %02h (len %0d vs %0d)",
               to, d, got_at(d), exp_at(d), got.size(), exp_pk.size());
    end
    checks++;
    if (pull_cnt - p0 != 1) begin
      errors++;
      $display("FAIL post_reset_pulls: got %0d required 1", pull_cnt - p0);
    end
    $display("reset_mid_packet: restart %0d bytes", got.size());
  endtask

  task automatic test_pull_rules();
    checks++;
    if (avail_err != 0) begin
      errors++;
      $display("FAIL pull_without_avail: got %0d required 0", avail_err);
    end
    checks++;
    if (gap_err != 0) begin
      errors++;
      $display("FAIL pull_spacing_total: got %0d required 0", gap_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_three();
    test_random_ready();
    test_seq_wrap();
    test_enable_drop();
    test_reset_mid_packet();
    test_pull_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
